// File: rtl/w_realign_stage.sv
// rtl/w_realign_stage.sv - rotates packed store data onto AXI W lanes with spill carry, strobes and last
module w_realign_stage #(
  parameter int unsigned AxiDataWidth = 512,
  parameter int unsigned NumTrackers  = 8,
  parameter int unsigned ByteCntWidth = 16,
  localparam int unsigned B    = AxiDataWidth / 8,
  localparam int unsigned OffW = $clog2(B),
  localparam int unsigned CntW = $clog2(NumTrackers) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [OffW-1:0]         req_offset_i,
  input  logic [ByteCntWidth-1:0] req_bytes_i,
  input  logic [AxiDataWidth-1:0] w_data_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [AxiDataWidth-1:0] w_data_o,
  output logic [B-1:0]            w_strb_o,
  output logic                    w_last_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [CntW-1:0]         pending_o
);

  localparam int unsigned PtrW = $clog2(NumTrackers);
  localparam logic [OffW:0] BeatBytes = (OffW+1)'(B);
  localparam logic [ByteCntWidth-1:0] BeatBytesCnt = ByteCntWidth'(B);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;
  state_e state_q, state_d;

  logic [OffW-1:0]         off_mem   [NumTrackers];
  logic [ByteCntWidth-1:0] bytes_mem [NumTrackers];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q, nxt_ptr;
  logic [CntW-1:0]         count_q, cnt_after;

  logic [OffW-1:0]         off_q, ld_off;
  logic [ByteCntWidth-1:0] rem_q, in_rem_q, ld_bytes, in_take, in_rem_nxt;
  logic                    first_q;
  logic [AxiDataWidth-1:0] carry_q, rot, lane_data;
  logic [B-1:0]            lane_strb;
  logic [OffW:0]           lo, room, n, hi;
  logic                    last, push, pop, in_hs, out_hs, load;
  logic [OffW+2:0]         rot_sh;

  assign req_ready_o = (count_q != CntW'(NumTrackers));
  assign push        = req_valid_i && req_ready_o;
  assign in_hs       = w_valid_i && w_ready_o;
  assign out_hs      = w_valid_o && w_ready_i;
  assign pop         = out_hs && last;
  assign cnt_after   = count_q - CntW'(1) + CntW'(push);
  assign pending_o   = count_q;
  assign nxt_ptr     = rd_ptr_q + PtrW'(1);

  always_ff @(posedge clk_i) begin
    if (push) begin
      off_mem[wr_ptr_q]   <= req_offset_i;
      bytes_mem[wr_ptr_q] <= req_bytes_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= nxt_ptr;
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // On a last-beat pop the next head may be the entry being pushed this very cycle.
  always_comb begin
    if (state_q == IDLE) begin
      ld_off   = off_mem[rd_ptr_q];
      ld_bytes = bytes_mem[rd_ptr_q];
    end else if (count_q == CntW'(1)) begin
      ld_off   = req_offset_i;
      ld_bytes = req_bytes_i;
    end else begin
      ld_off   = off_mem[nxt_ptr];
      ld_bytes = bytes_mem[nxt_ptr];
    end
  end

  assign load = ((state_q == IDLE) && (count_q != '0)) || (pop && (cnt_after != '0));

  assign rot_sh = {off_q, 3'b000};
  assign rot    = (w_data_i << rot_sh) | (w_data_i >> (AxiDataWidth - rot_sh));

  assign lo         = first_q ? {1'b0, off_q} : '0;
  assign room       = BeatBytes - lo;
  assign n          = (ByteCntWidth'(room) < rem_q) ? room : rem_q[OffW:0];
  assign hi         = lo + n;
  assign last       = (rem_q <= ByteCntWidth'(room));
  assign in_take    = (in_rem_q > BeatBytesCnt) ? BeatBytesCnt : in_rem_q;
  assign in_rem_nxt = in_rem_q - in_take;

  always_comb begin
    lane_data = '0;
    lane_strb = '0;
    for (int j = 0; j < B; j++) begin
      if ((OffW+1)'(j) < {1'b0, off_q}) begin
        lane_data[8*j +: 8] = carry_q[8*j +: 8];
      end else if (state_q != FLUSH) begin
        lane_data[8*j +: 8] = rot[8*j +: 8];
      end
      lane_strb[j] = ((OffW+1)'(j) >= lo) && ((OffW+1)'(j) < hi);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      off_q    <= '0;
      rem_q    <= '0;
      in_rem_q <= '0;
      first_q  <= 1'b0;
      carry_q  <= '0;
    end else begin
      if (load) begin
        off_q    <= ld_off;
        rem_q    <= ld_bytes;
        in_rem_q <= ld_bytes;
        first_q  <= 1'b1;
      end else if (out_hs) begin
        rem_q   <= rem_q - ByteCntWidth'(n);
        first_q <= 1'b0;
        if (in_hs) in_rem_q <= in_rem_nxt;
      end
      if (in_hs) carry_q <= rot;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (count_q != '0) state_d = RUN;
      RUN, FLUSH: begin
        if (out_hs) begin
          if (last)                                  state_d = (cnt_after != '0) ? RUN : IDLE;
          else if (in_hs && (in_rem_nxt == '0))      state_d = FLUSH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_valid_o = 1'b0;
    w_ready_o = 1'b0;
    w_data_o  = '0;
    w_strb_o  = '0;
    w_last_o  = 1'b0;
    case (state_q)
      RUN: begin
        w_valid_o = w_valid_i;
        w_ready_o = w_ready_i;
      end
      FLUSH:   w_valid_o = 1'b1;
      default: ;
    endcase
    if (state_q != IDLE) begin
      w_data_o = lane_data;
      w_strb_o = lane_strb;
      w_last_o = last;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!push || (req_bytes_i != '0));
      assert (!in_hs || (state_q == RUN));
      assert (count_q <= CntW'(NumTrackers));
    end
  end

endmodule

// File: tb/tb_w_realign_stage.sv
// tb/tb_w_realign_stage.sv - scoreboard bench for w_realign_stage with B=64
module tb_w_realign_stage;

  logic         clk;
  logic         rst_ni;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [5:0]   req_offset_i;
  logic [15:0]  req_bytes_i;
  logic [511:0] w_data_i;
  logic         w_valid_i;
  logic         w_ready_o;
  logic [511:0] w_data_o;
  logic [63:0]  w_strb_o;
  logic         w_last_o;
  logic         w_valid_o;
  logic         w_ready_i;
  logic [3:0]   pending_o;

  w_realign_stage dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_offset_i (req_offset_i),
    .req_bytes_i  (req_bytes_i),
    .w_data_i     (w_data_i),
    .w_valid_i    (w_valid_i),
    .w_ready_o    (w_ready_o),
    .w_data_o     (w_data_o),
    .w_strb_o     (w_strb_o),
    .w_last_o     (w_last_o),
    .w_valid_o    (w_valid_o),
    .w_ready_i    (w_ready_i),
    .pending_o    (pending_o)
  );

  typedef struct {
    logic [511:0] data;
    logic [63:0]  strb;
    logic         last;
    logic         rdy;
  } beat_t;

  beat_t        exp_q[$];
  logic [511:0] in_q[$];
  int           hs_cyc[$];
  logic [63:0]  strb_log[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int in_cnt = 0;
  int exp_in = 0;
  logic drv_en, drv_junk, drv_hs;
  beat_t mon_e;
  logic [511:0] mon_mask;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  // Reference: packed byte i lands at address off+i, i.e. beat (off+i)/64, lane (off+i)%64.
  task automatic plan(input int off, input int nbytes);
    logic [511:0] beats[$];
    logic [511:0] d;
    beat_t e;
    int nin, nout, idx;
    nin  = (nbytes + 63) / 64;
    nout = (off + nbytes + 63) / 64;
    for (int i = 0; i < nin; i++) begin
      d = rand512();
      beats.push_back(d);
      in_q.push_back(d);
    end
    for (int k = 0; k < nout; k++) begin
      e.data = '0;
      e.strb = '0;
      e.last = (k == nout - 1);
      e.rdy  = (k < nin);
      for (int l = 0; l < 64; l++) begin
        idx = k * 64 + l - off;
        if (idx >= 0 && idx < nbytes) begin
          e.strb[l] = 1'b1;
          d = beats[idx / 64];
          e.data[8*l +: 8] = d[8*(idx % 64) +: 8];
        end
      end
      exp_q.push_back(e);
    end
    exp_in += nin;
  endtask

  task automatic send_req(input int off, input int nbytes);
    int n;
    plan(off, nbytes);
    @(posedge clk); #1;
    req_valid_i  = 1'b1;
    req_offset_i = 6'(off);
    req_bytes_i  = 16'(nbytes);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_o && n < 200);
    checks++;
    assert (req_ready_o) else begin
      failures++;
      $error("FAIL req_accept_timeout observed=%0d expected=%0d", req_ready_o, 1);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_drain"}, 512'(exp_q.size()), 512'(0));
    repeat (2) @(posedge clk);
    #2;
    chk({tag, "_in_q_empty"}, 512'(in_q.size()), 512'(0));
    chk({tag, "_in_beats"}, 512'(in_cnt), 512'(exp_in));
    chk({tag, "_pending"}, 512'(pending_o), 512'(0));
  endtask

  task automatic clear_log();
    hs_cyc.delete();
    strb_log.delete();
  endtask

  always @(negedge clk) begin
    if (rst_ni && w_valid_o) begin
      if (w_ready_i) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_beat observed=%0h expected=none", w_strb_o);
        end
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          for (int l = 0; l < 64; l++) mon_mask[8*l +: 8] = {8{mon_e.strb[l]}};
          chk("beat_strb", 512'(w_strb_o), 512'(mon_e.strb));
          chk("beat_last", 512'(w_last_o), 512'(mon_e.last));
          chk("beat_data", w_data_o & mon_mask, mon_e.data);
          chk("beat_in_ready", 512'(w_ready_o), 512'(mon_e.rdy));
        end
        hs_cyc.push_back(cyc);
        strb_log.push_back(w_strb_o);
      end else if (exp_q.size() > 0) begin
        mon_e = exp_q[0];
        for (int l = 0; l < 64; l++) mon_mask[8*l +: 8] = {8{mon_e.strb[l]}};
        chk("stall_strb", 512'(w_strb_o), 512'(mon_e.strb));
        chk("stall_last", 512'(w_last_o), 512'(mon_e.last));
        chk("stall_data", w_data_o & mon_mask, mon_e.data);
      end
    end
  end

  initial begin
    w_valid_i = 1'b0;
    w_data_i  = '0;
    drv_hs    = 1'b0;
    forever begin
      @(negedge clk);
      drv_hs = w_valid_i && w_ready_o;
      @(posedge clk); #1;
      if (drv_hs && !drv_junk && in_q.size() > 0) begin
        void'(in_q.pop_front());
        in_cnt++;
      end
      if (drv_junk) begin
        w_valid_i = 1'b1;
        w_data_i  = rand512();
      end else if (drv_en && in_q.size() > 0) begin
        w_valid_i = 1'b1;
        w_data_i  = in_q[0];
      end else begin
        w_valid_i = 1'b0;
      end
    end
  end

  initial begin
    int n;
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    req_offset_i = '0;
    req_bytes_i = '0;
    w_ready_i = 1'b0;
    drv_en = 1'b0;
    drv_junk = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 512'(req_ready_o), 512'(1));
    chk("rst_w_valid", 512'(w_valid_o), 512'(0));
    chk("rst_w_ready", 512'(w_ready_o), 512'(0));
    chk("rst_strb", 512'(w_strb_o), 512'(0));
    chk("rst_last", 512'(w_last_o), 512'(0));
    chk("rst_data", w_data_o, 512'(0));
    chk("rst_pending", 512'(pending_o), 512'(0));
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // aligned two-beat store
    w_ready_i = 1'b1;
    drv_en = 1'b1;
    clear_log();
    send_req(0, 128);
    drain("t1");
    chk("t1_beats", 512'(hs_cyc.size()), 512'(2));
    if (hs_cyc.size() >= 2) begin
      chk("t1_strb0", 512'(strb_log[0]), 512'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("t1_gap", 512'(hs_cyc[1] - hs_cyc[0]), 512'(1));
    end

    // offset 8: one input beat, then a flush beat
    clear_log();
    send_req(8, 64);
    drain("t2");
    chk("t2_beats", 512'(hs_cyc.size()), 512'(2));
    if (hs_cyc.size() >= 2) begin
      chk("t2_strb0", 512'(strb_log[0]), 512'(64'hFFFF_FFFF_FFFF_FF00));
      chk("t2_strb1", 512'(strb_log[1]), 512'(64'h0000_0000_0000_00FF));
    end

    // offset 60, 8 bytes straddling a beat boundary
    clear_log();
    send_req(60, 8);
    drain("t3");
    chk("t3_beats", 512'(hs_cyc.size()), 512'(2));
    if (hs_cyc.size() >= 2) begin
      chk("t3_strb0", 512'(strb_log[0]), 512'(64'hF000_0000_0000_0000));
      chk("t3_strb1", 512'(strb_log[1]), 512'(64'h0000_0000_0000_000F));
    end

    // fill the tracker with the W path stalled
    clear_log();
    w_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send_req(0, 64);
    @(negedge clk);
    chk("t4_pending_full", 512'(pending_o), 512'(8));
    chk("t4_req_ready_full", 512'(req_ready_o), 512'(0));
    @(posedge clk); #1;
    w_ready_i    = 1'b1;
    req_valid_i  = 1'b1;
    req_offset_i = 6'd0;
    req_bytes_i  = 16'd64;
    @(negedge clk);
    chk("t4_pop_last", 512'(w_last_o && w_valid_o), 512'(1));
    chk("t4_push_blocked", 512'(req_ready_o), 512'(0));
    @(posedge clk); #1;
    w_ready_i   = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("t4_pending_after_pop", 512'(pending_o), 512'(7));
    chk("t4_req_ready_after_pop", 512'(req_ready_o), 512'(1));
    @(posedge clk); #1;
    w_ready_i = 1'b1;
    drain("t4");
    chk("t4_beats", 512'(hs_cyc.size()), 512'(8));

    // back-to-back requests, no bubble between them
    clear_log();
    w_ready_i = 1'b0;
    send_req(4, 60);
    send_req(0, 64);
    repeat (2) @(posedge clk);
    #1;
    w_ready_i = 1'b1;
    drain("t5");
    chk("t5_beats", 512'(hs_cyc.size()), 512'(2));
    if (hs_cyc.size() >= 2) begin
      chk("t5_no_bubble", 512'(hs_cyc[1] - hs_cyc[0]), 512'(1));
      chk("t5_strb0", 512'(strb_log[0]), 512'(64'hFFFF_FFFF_FFFF_FFF0));
    end

    // random downstream backpressure
    clear_log();
    w_ready_i = 1'b0;
    send_req(32, 200);
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(posedge clk); #1;
      w_ready_i = 1'($urandom_range(0, 1));
      n++;
    end
    w_ready_i = 1'b1;
    drain("t6");
    chk("t6_beats", 512'(hs_cyc.size()), 512'(4));
    if (strb_log.size() > 0)
      chk("t6_last_strb", 512'(strb_log[strb_log.size()-1]), 512'(64'h0000_00FF_FFFF_FFFF));

    // reset in the middle of a burst
    clear_log();
    plan(8, 200);
    @(posedge clk); #1;
    req_valid_i  = 1'b1;
    req_offset_i = 6'd8;
    req_bytes_i  = 16'd200;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    n = 0;
    while (hs_cyc.size() == 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t7_first_beat_seen", 512'(hs_cyc.size() > 0), 512'(1));
    #1;
    rst_ni = 1'b0;
    drv_en = 1'b0;
    in_q.delete();
    exp_q.delete();
    exp_in = in_cnt;
    #1;
    chk("t7_rst_w_valid", 512'(w_valid_o), 512'(0));
    chk("t7_rst_strb", 512'(w_strb_o), 512'(0));
    chk("t7_rst_last", 512'(w_last_o), 512'(0));
    chk("t7_rst_data", w_data_o, 512'(0));
    chk("t7_rst_pending", 512'(pending_o), 512'(0));
    chk("t7_rst_req_ready", 512'(req_ready_o), 512'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    drv_junk = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t7_idle_w_valid", 512'(w_valid_o), 512'(0));
      chk("t7_idle_w_ready", 512'(w_ready_o), 512'(0));
    end
    @(posedge clk); #1;
    drv_junk = 1'b0;
    drv_en = 1'b1;
    clear_log();
    send_req(0, 64);
    drain("t7_recover");
    chk("t7_recover_beats", 512'(hs_cyc.size()), 512'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
